// File: rtl/mem_bus_arbiter.sv
// Shares one addr_ok/data_ok memory bus between the fetch port and the load/store port.
// Optional ARB_TIMEOUT_EN macro builds a per-transaction watchdog that drives bus_err.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        stallreq_from_if,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        stallreq_from_mem,
  input  logic        pipe_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA} state_t;

  state_t state, state_nx;
  logic   i_done, d_done;
  logic   cap_d, cap_i, fin, abort;
  logic   is_data, is_inst;

  assign is_data = (state == D_ADDR) || (state == D_DATA);
  assign is_inst = (state == I_ADDR) || (state == I_DATA);
  assign bus_req = (state == D_ADDR) || (state == I_ADDR);

  assign stallreq_from_if  = inst_req & ~i_done;
  assign stallreq_from_mem = data_req & ~d_done;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] tmo_cnt;
  logic          bus_err_q;

  // A real completion in the expiry cycle takes precedence over the timeout.
  assign abort = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) && !fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= abort;
      if (state == IDLE || fin || abort) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cap_d    = 1'b0;
    cap_i    = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (data_req && !d_done) begin
          cap_d    = 1'b1;
          state_nx = D_ADDR;
        end else if (inst_req && !i_done) begin
          cap_i    = 1'b1;
          state_nx = I_ADDR;
        end
      end
      D_ADDR, I_ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            fin      = 1'b1;
            state_nx = IDLE;
          end else if (state == D_ADDR) begin
            state_nx = D_DATA;
          end else begin
            state_nx = I_DATA;
          end
        end
      end
      D_DATA, I_DATA: begin
        if (bus_data_ok) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus_wr     <= 1'b0;
      bus_size   <= 2'd0;
      bus_sel    <= 4'd0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
    end else begin
      state <= state_nx;
      if (cap_d) begin
        bus_wr    <= data_wr;
        bus_size  <= data_size;
        bus_sel   <= data_sel;
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
      end else if (cap_i) begin
        bus_wr   <= 1'b0;
        bus_size <= 2'd2;
        bus_sel  <= 4'hF;
        bus_addr <= inst_addr;
      end
      // Clear on pipeline advance, but a completion in the same edge must stick.
      if (!pipe_stall) begin
        i_done <= 1'b0;
        d_done <= 1'b0;
      end
      if ((fin || abort) && is_inst) i_done <= 1'b1;
      if ((fin || abort) && is_data) d_done <= 1'b1;
      if (fin && is_inst)              inst_rdata <= bus_rdata;
      if (fin && is_data && !bus_wr)   data_rdata <= bus_rdata;
      if (abort && is_inst)            inst_rdata <= 32'd0;
      if (abort && is_data)            data_rdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; the bus slave is played cycle by cycle from the stimulus.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        stallreq_from_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stallreq_from_mem;
  logic        pipe_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .stallreq_from_if(stallreq_from_if),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .stallreq_from_mem(stallreq_from_mem), .pipe_stall(pipe_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs changed after this settle well before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_sel = 0; data_addr = 0; data_wdata = 0; pipe_stall = 1'b1;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    step(); step();
    rst = 1'b0;
    settle();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_sel", bus_sel, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_bus_err", bus_err, 0);

    // Fetch only: addr_ok at 1, data_ok at 3; held done with pipe_stall=1.
    inst_req = 1; inst_addr = 32'hBFC00000; settle();
    chk("f_c0_stall", stallreq_from_if, 1);
    step(); bus_addr_ok = 1; settle();
    chk("f_c1_req", bus_req, 1);
    chk("f_c1_addr", bus_addr, 32'hBFC00000);
    chk("f_c1_selsz", {bus_wr, bus_size, bus_sel}, {1'b0, 2'd2, 4'hF});
    chk("f_c1_stall", stallreq_from_if, 1);
    step(); bus_addr_ok = 0; settle();
    chk("f_c2_req", bus_req, 0);
    chk("f_c2_stall", stallreq_from_if, 1);
    step(); bus_data_ok = 1; bus_rdata = 32'h24080001; settle();
    chk("f_c3_stall", stallreq_from_if, 1);
    step(); bus_data_ok = 0; bus_rdata = 0; settle();
    chk("f_c4_stall", stallreq_from_if, 0);
    chk("f_c4_rdata", inst_rdata, 32'h24080001);

    // Held done: no re-issue while pipe_stall stays high.
    for (int i = 0; i < 5; i++) begin
      step(); settle();
      chk("hold_req", bus_req, 0);
      chk("hold_stall", stallreq_from_if, 0);
      chk("hold_rdata", inst_rdata, 32'h24080001);
    end
    pipe_stall = 0;
    step(); inst_addr = 32'hBFC00004; settle();
    chk("rel_stall", stallreq_from_if, 1);
    step(); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h11111111; settle();
    chk("rel_req", bus_req, 1);
    chk("rel_addr", bus_addr, 32'hBFC00004);
    step(); bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0; inst_req = 0; settle();
    chk("fast_rdata", inst_rdata, 32'h11111111);
    chk("fast_req", bus_req, 0);
    step(); step();

    // Simultaneous requests: data goes first.
    pipe_stall = 1;
    inst_req = 1; inst_addr = 32'hBFC00008;
    data_req = 1; data_wr = 0; data_addr = 32'h80000010; data_size = 2; data_sel = 4'hF;
    step(); bus_addr_ok = 1; settle();
    chk("pri_addr", bus_addr, 32'h80000010);
    chk("pri_req", bus_req, 1);
    chk("pri_stalls", {stallreq_from_if, stallreq_from_mem}, 2'b11);
    step(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hCAFEBABE; settle();
    chk("pri_d2_addr", bus_addr, 32'h80000010);
    step(); bus_data_ok = 0; bus_rdata = 0; settle();
    chk("pri_d_stall", {stallreq_from_if, stallreq_from_mem}, 2'b10);
    chk("pri_d_rdata", data_rdata, 32'hCAFEBABE);
    step(); bus_addr_ok = 1; settle();
    chk("pri_i_addr", bus_addr, 32'hBFC00008);
    chk("pri_i_req", bus_req, 1);
    step(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h00000013; settle();
    step(); bus_data_ok = 0; bus_rdata = 0; settle();
    chk("pri_i_stall", stallreq_from_if, 0);
    chk("pri_i_rdata", inst_rdata, 32'h00000013);
    pipe_stall = 0; inst_req = 0; data_req = 0;
    step(); step();

    // Store: command fields forwarded, data_rdata untouched.
    pipe_stall = 1;
    data_req = 1; data_wr = 1; data_sel = 4'b0011; data_wdata = 32'h00001234;
    data_addr = 32'h80000020; data_size = 2'd1;
    step(); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hDEADBEEF; settle();
    chk("st_wr", bus_wr, 1);
    chk("st_sel", bus_sel, 4'b0011);
    chk("st_wdata", bus_wdata, 32'h00001234);
    chk("st_size", bus_size, 2'd1);
    step(); bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0; settle();
    chk("st_stall", stallreq_from_mem, 0);
    chk("st_rdata", data_rdata, 32'hCAFEBABE);
    pipe_stall = 0; data_req = 0; data_wr = 0;
    step(); step();

    // Stray acks while idle.
    bus_data_ok = 1; bus_addr_ok = 1; bus_rdata = 32'h55555555;
    step(); settle();
    chk("idle_ack_d", data_rdata, 32'hCAFEBABE);
    chk("idle_ack_i", inst_rdata, 32'h00000013);
    chk("idle_ack_req", bus_req, 0);
    bus_data_ok = 0; bus_addr_ok = 0; bus_rdata = 0;
    step();

    // Reset while in D_DATA; a late data_ok is then ignored.
    pipe_stall = 1;
    data_req = 1; data_wr = 0; data_addr = 32'h80000030; data_sel = 4'hF; data_size = 2;
    step(); bus_addr_ok = 1;
    step(); bus_addr_ok = 0; rst = 1;
    step(); data_req = 0; settle();
    chk("mrst_req", bus_req, 0);
    chk("mrst_addr", bus_addr, 0);
    chk("mrst_cmd", {bus_wr, bus_size, bus_sel}, 0);
    chk("mrst_wdata", bus_wdata, 0);
    chk("mrst_rdata", {inst_rdata, data_rdata}, 0);
    rst = 0; bus_data_ok = 1; bus_rdata = 32'h77777777;
    step(); bus_data_ok = 0; bus_rdata = 0; settle();
    chk("late_ack_rdata", data_rdata, 0);
    chk("late_ack_req", bus_req, 0);
    pipe_stall = 0;
    step();

    // Give inst_rdata a nonzero value first so a forced zero is visible.
    pipe_stall = 1; inst_req = 1; inst_addr = 32'hBFC00010;
    step(); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hABCD0001;
    step(); bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0; settle();
    chk("pre_tmo_rdata", inst_rdata, 32'hABCD0001);
    pipe_stall = 0;
    step(); inst_addr = 32'hBFC00014;
    step(); pipe_stall = 1;
`ifdef ARB_TIMEOUT_EN
    begin
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        step(); settle();
        if (bus_err) seen = 1;
      end
      chk("tmo_err_seen", seen, 1);
      chk("tmo_stall", stallreq_from_if, 0);
      chk("tmo_rdata", inst_rdata, 0);
      step(); settle();
      chk("tmo_err_pulse", bus_err, 0);
    end
`else
    for (int i = 0; i < 40; i++) step();
    settle();
    chk("notmo_err", bus_err, 0);
    chk("notmo_stall", stallreq_from_if, 1);
    chk("notmo_rdata", inst_rdata, 32'hABCD0001);
    bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h0000BEEF;
    step(); bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0; settle();
    chk("notmo_late_done", inst_rdata, 32'h0000BEEF);
`endif
    inst_req = 0; pipe_stall = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
